// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM slave: widths,
// burst/resp encodings, FSM states and the beat address step.
package axi_pkg;

  localparam int AXI_DATA_WIDTH = 128;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int AXI_ID_WIDTH   = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  function automatic logic [31:0] beat_next(
    input logic [31:0] addr,
    input logic [2:0]  size,
    input logic [1:0]  burst
  );
    if (burst == BURST_INCR) return addr + (32'd1 << size);
    return addr;
  endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// 128-bit byte-enabled storage, one registered read port
// and one write port; reads return pre-write contents.
module axi_sram_mem
  import axi_pkg::*;
#(
  parameter int WORDS = 4096,
  parameter int AW    = 12
) (
  input  logic                      clock,
  input  logic                      re,
  input  logic [AW-1:0]             raddr,
  output logic [AXI_DATA_WIDTH-1:0] rdata,
  input  logic                      we,
  input  logic [AW-1:0]             waddr,
  input  logic [AXI_STRB_WIDTH-1:0] wstrb,
  input  logic [AXI_DATA_WIDTH-1:0] wdata
);

  logic [AXI_DATA_WIDTH-1:0] mem_q [WORDS];
  logic [AXI_DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (re) rdata_q <= mem_q[raddr];
    if (we) begin
      for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
        if (wstrb[b]) mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave in front of an on-chip SRAM: independent read and
// write FSMs, INCR/FIXED bursts, SLVERR on illegal beats.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h1C00_0000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [3:0]   arid,
  input  logic [31:0]  araddr,
  input  logic [7:0]   arlen,
  input  logic [2:0]   arsize,
  input  logic [1:0]   arburst,
  input  logic         arvalid,
  output logic         arready,
  output logic [3:0]   rid,
  output logic [127:0] rdata,
  output logic [1:0]   rresp,
  output logic         rlast,
  output logic         rvalid,
  input  logic         rready,
  input  logic [3:0]   awid,
  input  logic [31:0]  awaddr,
  input  logic [7:0]   awlen,
  input  logic [2:0]   awsize,
  input  logic [1:0]   awburst,
  input  logic         awvalid,
  output logic         awready,
  input  logic [127:0] wdata,
  input  logic [15:0]  wstrb,
  input  logic         wlast,
  input  logic         wvalid,
  output logic         wready,
  output logic [3:0]   bid,
  output logic [1:0]   bresp,
  output logic         bvalid,
  input  logic         bready
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] LIMIT = 33'(MEM_WORDS) << 4;

  function automatic logic in_rng(input logic [31:0] a);
    return (a >= BASE_ADDR) &&
           ((33'(a) - 33'(BASE_ADDR)) < LIMIT);
  endfunction

  function automatic logic beat_bad(
    input logic [31:0] a,
    input logic [2:0]  size,
    input logic [1:0]  burst
  );
    logic legal;
    legal = (burst == BURST_FIXED) || (burst == BURST_INCR);
    return !legal || (size > 3'd4) || !in_rng(a);
  endfunction

  function automatic logic [AW-1:0] widx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 4);
  endfunction

  rd_state_e    r_state_q, r_state_d;
  logic [3:0]   r_id_q,    r_id_d;
  logic [31:0]  r_addr_q,  r_addr_d;
  logic [7:0]   r_len_q,   r_len_d;
  logic [2:0]   r_size_q,  r_size_d;
  logic [1:0]   r_burst_q, r_burst_d;
  logic [7:0]   r_cnt_q,   r_cnt_d;
  logic         arready_q, arready_d;

  wr_state_e    w_state_q, w_state_d;
  logic [3:0]   w_id_q,    w_id_d;
  logic [31:0]  w_addr_q,  w_addr_d;
  logic [7:0]   w_len_q,   w_len_d;
  logic [2:0]   w_size_q,  w_size_d;
  logic [1:0]   w_burst_q, w_burst_d;
  logic [7:0]   w_cnt_q,   w_cnt_d;
  logic         w_err_q,   w_err_d;
  logic         awready_q, awready_d;

  logic         mem_re, mem_we;
  logic [31:0]  rd_addr;
  logic [31:0]  r_next;
  logic         r_bad, w_bad;
  logic [127:0] mem_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      arready_q <= 1'b0;
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
      arready_q <= arready_d;
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      awready_q <= awready_d;
    end
  end

  // The SRAM read is issued one beat ahead so data lands with rvalid.
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    rd_addr   = araddr;
    mem_re    = 1'b0;
    rvalid    = (r_state_q == R_BURST);
    rlast     = rvalid && (r_cnt_q == r_len_q);
    r_next    = beat_next(r_addr_q, r_size_q, r_burst_q);
    case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          r_id_d    = arid;
          r_addr_d  = araddr;
          r_len_d   = arlen;
          r_size_d  = arsize;
          r_burst_d = arburst;
          r_cnt_d   = '0;
          r_state_d = R_BURST;
          mem_re    = in_rng(araddr);
        end
      end
      R_BURST: begin
        if (rready) begin
          if (rlast) begin
            r_state_d = R_IDLE;
          end else begin
            r_addr_d = r_next;
            r_cnt_d  = r_cnt_q + 8'd1;
            rd_addr  = r_next;
            mem_re   = in_rng(r_next);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  assign r_bad   = beat_bad(r_addr_q, r_size_q, r_burst_q);
  assign arready = arready_q;
  assign rid     = r_id_q;
  assign rdata   = (rvalid && !r_bad) ? mem_rdata : '0;
  assign rresp   = (rvalid && r_bad) ? RESP_SLVERR : RESP_OKAY;

  assign w_bad = beat_bad(w_addr_q, w_size_q, w_burst_q);

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    mem_we    = 1'b0;
    wready    = (w_state_q == W_DATA);
    bvalid    = (w_state_q == W_RESP);
    case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready_q) begin
          w_id_d    = awid;
          w_addr_d  = awaddr;
          w_len_d   = awlen;
          w_size_d  = awsize;
          w_burst_d = awburst;
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          mem_we   = !w_bad;
          // wlast must coincide exactly with beat awlen.
          w_err_d  = w_err_q | w_bad |
                     (wlast != (w_cnt_q == w_len_q));
          w_addr_d = beat_next(w_addr_q, w_size_q, w_burst_q);
          w_cnt_d  = w_cnt_q + 8'd1;
          if (wlast) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
  end

  assign awready = awready_q;
  assign bid     = w_id_q;
  assign bresp   = (bvalid && w_err_q) ? RESP_SLVERR : RESP_OKAY;

  axi_sram_mem #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_mem (
    .clock (clock),
    .re    (mem_re),
    .raddr (widx(rd_addr)),
    .rdata (mem_rdata),
    .we    (mem_we),
    .waddr (widx(w_addr_q)),
    .wstrb (wstrb),
    .wdata (wdata)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed plus randomized bench for axi_sram_slave against a
// byte-array memory model and burst address rules.
module tb_axi_sram_slave;

  localparam int          MW   = 64;
  localparam logic [31:0] BASE = 32'h1C00_0000;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [MW*16];

  always #5 clock = ~clock;

  axi_sram_slave #(.MEM_WORDS(MW), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic bad(input logic [31:0] a,
                               input logic [2:0] sz,
                               input logic [1:0] bu);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (bu > 2'b01) || (sz > 3'd4) || (off < 0) || (off >= 16 * MW);
  endfunction

  function automatic logic [31:0] step(input logic [31:0] a,
                                       input logic [2:0] sz,
                                       input logic [1:0] bu);
    return (bu == 2'b01) ? a + (32'd1 << sz) : a;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 4);
  endfunction

  function automatic logic [127:0] exp_word(input logic [31:0] a);
    logic [127:0] v;
    int w;
    w = word_of(a);
    for (int b = 0; b < 16; b++) v[b*8 +: 8] = mdl[w*16 + b];
    return v;
  endfunction

  task automatic wr(input logic [3:0] id, input logic [31:0] a,
                    input logic [7:0] len, input logic [2:0] sz,
                    input logic [1:0] bu, input int last_at,
                    input logic [15:0] smask, input bit rnd_strb);
    logic ok, eerr;
    logic [31:0] cur;
    int n;
    cur = a;
    eerr = (last_at != int'(len));
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu;
    awvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clock); ok = awready;
      @(posedge clock); #1; n++;
    end while (!ok && n < 50);
    awvalid = 1'b0;
    chk("aw_handshake", ok, 1);
    for (int i = 0; i <= last_at; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        @(posedge clock); #1;
      end
      wdata  = {$urandom, $urandom, $urandom, $urandom};
      wstrb  = rnd_strb ? (16'($urandom) & smask) : smask;
      wlast  = (i == last_at);
      wvalid = 1'b1;
      n = 0;
      do begin
        @(negedge clock); ok = wready;
        @(posedge clock); #1; n++;
      end while (!ok && n < 50);
      if (!ok) chk("w_handshake", ok, 1);
      if (!bad(cur, sz, bu)) begin
        for (int b = 0; b < 16; b++)
          if (wstrb[b]) mdl[word_of(cur)*16 + b] = wdata[b*8 +: 8];
      end
      eerr = eerr | bad(cur, sz, bu);
      cur = step(cur, sz, bu);
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    do begin
      @(negedge clock); ok = bvalid;
      if (!ok) begin @(posedge clock); #1; end
      n++;
    end while (!ok && n < 50);
    chk("b_valid", ok, 1);
    chk("bresp", bresp, eerr ? 2'b10 : 2'b00);
    chk("bid", bid, id);
    @(posedge clock); #1;
    chk("bresp_hold", bresp, eerr ? 2'b10 : 2'b00);
    @(negedge clock); bready = 1'b1;
    @(posedge clock); #1; bready = 1'b0;
    chk("b_done", {bvalid, awready}, 2'b01);
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] a,
                    input logic [7:0] len, input logic [2:0] sz,
                    input logic [1:0] bu, input bit toggle,
                    input int abort_at);
    logic ok, hs, first, eb;
    logic [31:0] cur;
    int n, beat;
    cur = a;
    rready = 1'b0;
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu;
    arvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clock); ok = arready;
      @(posedge clock); #1; n++;
    end while (!ok && n < 50);
    arvalid = 1'b0;
    chk("ar_handshake", ok, 1);
    beat = 0; n = 0; first = 1'b1;
    while (beat <= int'(len) && !(abort_at >= 0 && beat == abort_at)
           && n < 2000) begin
      rready = toggle ? ~rready : 1'b1;
      @(negedge clock);
      if (first) chk("r_first_latency", rvalid, 1);
      first = 1'b0;
      hs = 1'b0;
      if (rvalid) begin
        eb = bad(cur, sz, bu);
        chk("rdata", rdata, eb ? 128'd0 : exp_word(cur));
        chk("rresp", rresp, eb ? 2'b10 : 2'b00);
        chk("rlast", rlast, beat == int'(len));
        chk("rid", rid, id);
        hs = rready;
      end
      @(posedge clock); #1; n++;
      if (hs) begin
        beat++;
        cur = step(cur, sz, bu);
      end
    end
    if (abort_at < 0) begin
      chk("r_beats", beat, int'(len) + 1);
      rready = 1'b0;
      @(negedge clock);
      chk("r_done", {rvalid, arready}, 2'b01);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    reset = 1'b1;
    {arid, araddr, arlen, arsize, arburst, arvalid, rready} = '0;
    {awid, awaddr, awlen, awsize, awburst, awvalid} = '0;
    {wdata, wstrb, wlast, wvalid, bready} = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", {arready, awready, wready}, 3'b000);
    chk("rst_valid", {rvalid, bvalid, rlast}, 3'b000);
    chk("rst_ids", {rid, bid, rresp, bresp}, 12'd0);
    chk("rst_rdata", rdata, 128'd0);
    @(posedge clock); #1; reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_release", {arready, awready}, 2'b11);

    // fill all of memory so the model is fully known
    wr(4'd0, BASE, 8'(MW - 1), 3'd4, 2'b01, MW - 1, 16'hFFFF, 1'b0);

    wr(4'd5, BASE, 8'd0, 3'd4, 2'b01, 0, 16'hFFFF, 1'b0);
    rd(4'd5, BASE, 8'd0, 3'd4, 2'b01, 1'b0, -1);

    wr(4'd3, BASE + 32, 8'd3, 3'd4, 2'b01, 3, 16'h000F, 1'b0);
    rd(4'd3, BASE + 32, 8'd3, 3'd4, 2'b01, 1'b1, -1);

    rd(4'd1, BASE + 16*MW - 16, 8'd1, 3'd4, 2'b01, 1'b0, -1);
    rd(4'd2, BASE + 64, 8'd3, 3'd4, 2'b10, 1'b0, -1);
    rd(4'd2, BASE + 64, 8'd1, 3'd4, 2'b11, 1'b0, -1);
    rd(4'd4, BASE + 64, 8'd1, 3'd5, 2'b01, 1'b0, -1);
    rd(4'd4, BASE - 16, 8'd1, 3'd4, 2'b01, 1'b1, -1);

    wr(4'd7, BASE + 128, 8'd2, 3'd4, 2'b01, 1, 16'hFFFF, 1'b0);
    wr(4'd8, BASE + 16*MW - 16, 8'd1, 3'd4, 2'b01, 1, 16'hFFFF, 1'b0);
    rd(4'd8, BASE + 16*MW - 32, 8'd1, 3'd4, 2'b01, 1'b0, -1);
    wr(4'd9, BASE, 8'd255, 3'd0, 2'b01, 255, 16'hFFFF, 1'b1);
    rd(4'd9, BASE, 8'd15, 3'd4, 2'b01, 1'b1, -1);

    for (int k = 0; k < 6; k++) begin
      a = BASE + 32'(16 * $urandom_range(16, 47)) + 32'($urandom_range(0, 15));
      l = 8'($urandom_range(0, 7));
      wr(4'($urandom), a, l, 3'd4, 2'($urandom_range(0, 1)), int'(l),
         16'hFFFF, 1'b1);
      a = BASE + 32'(16 * $urandom_range(16, 47)) + 32'($urandom_range(0, 15));
      rd(4'($urandom), a, 8'($urandom_range(0, 7)),
         3'($urandom_range(0, 4)), 2'($urandom_range(0, 1)),
         1'($urandom), -1);
    end

    fork
      wr(4'd10, BASE + 16*20, 8'd3, 3'd4, 2'b01, 3, 16'hFFFF, 1'b1);
      rd(4'd11, BASE + 16*30, 8'd3, 3'd4, 2'b01, 1'b1, -1);
    join

    rd(4'd6, BASE, 8'd7, 3'd4, 2'b01, 1'b0, 2);
    reset = 1'b1;
    #1;
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_ready", {arready, rlast}, 2'b00);
    chk("midrst_rdata", rdata, 128'd0);
    rready = 1'b0;
    @(posedge clock); #1; reset = 1'b0;
    @(posedge clock); #1;
    chk("midrst_release", {arready, awready}, 2'b11);
    rd(4'd6, BASE, 8'd7, 3'd4, 2'b01, 1'b1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave
Interface
REQ-001 SHALL take parameter MEM_WORDS, default 4096, giving the number of 128-bit storage words.
REQ-002 SHALL take parameter BASE_ADDR, default 32'h1C00_0000, giving the byte address of word 0.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset (already decided).
REQ-005 arid, input, 4 bits: read ID.
REQ-006 araddr, input, 32 bits: read byte address.
REQ-007 arlen, input, 8 bits: read beats minus 1.
REQ-008 arsize, input, 3 bits: log2 of bytes per read beat.
REQ-009 arburst, input, 2 bits: read burst type.
REQ-010 arvalid, input, 1 bit: read address valid.
REQ-011 arready, output, 1 bit: read address accept.
REQ-012 rid, output, 4 bits: read ID echo.
REQ-013 rdata, output, 128 bits: read data.
REQ-014 rresp, output, 2 bits: read response.
REQ-015 rlast, output, 1 bit: final read beat.
REQ-016 rvalid, output, 1 bit: read data valid.
REQ-017 rready, input, 1 bit: master accepts read beat.
REQ-018 awid, input, 4 bits: write ID.
REQ-019 awaddr, input, 32 bits: write byte address.
REQ-020 awlen, input, 8 bits: write beats minus 1.
REQ-021 awsize, input, 3 bits: log2 of bytes per write beat.
REQ-022 awburst, input, 2 bits: write burst type.
REQ-023 awvalid, input, 1 bit: write address valid.
REQ-024 awready, output, 1 bit: write address accept.
REQ-025 wdata, input, 128 bits: write data.
REQ-026 wstrb, input, 16 bits: byte enables.
REQ-027 wlast, input, 1 bit: final write beat.
REQ-028 wvalid, input, 1 bit: write data valid.
REQ-029 wready, output, 1 bit: write data accept.
REQ-030 bid, output, 4 bits: write ID echo.
REQ-031 bresp, output, 2 bits: write response.
REQ-032 bvalid, output, 1 bit: write response valid.
REQ-033 bready, input, 1 bit: master accepts response.
Function
REQ-034 The read FSM SHALL have states R_IDLE and R_BURST. arready SHALL be 1 only in R_IDLE. On an arvalid&arready handshake the block SHALL latch id, addr, len, size and burst and enter R_BURST; rvalid SHALL assert the next cycle carrying beat 0.
REQ-035 rdata, rresp, rid and rlast SHALL hold stable while rvalid&!rready. Each rvalid&rready handshake SHALL advance the 8-bit beat counter; rlast SHALL be 1 on beat len (len=255 gives 256 beats). After the last handshake the FSM SHALL return to R_IDLE, with arready high the following cycle.
REQ-036 Beat address SHALL be computed as follows: INCR (2'b01) adds 1<<size per beat, modulo 2^32; FIXED (2'b00) holds the address. Word index = (addr-BASE_ADDR)>>4.
REQ-037 A beat SHALL get rresp 2'b10 (SLVERR) and rdata 0 if: burst is WRAP or reserved, or size>4, or addr is outside [BASE_ADDR, BASE_ADDR+16*MEM_WORDS). Otherwise rresp SHALL be 2'b00.
REQ-038 The write FSM SHALL have states W_IDLE, W_DATA and W_RESP. awready SHALL be 1 only in W_IDLE; wready SHALL be 1 only in W_DATA. Each wvalid&wready handshake SHALL write only the bytes whose wstrb bit is set. Addressing and error rules SHALL be as for reads; an errored beat SHALL NOT write memory.
REQ-039 A sticky error flag SHALL be set if wlast arrives before beat awlen, or beat awlen arrives without wlast. W_DATA SHALL exit only on a wlast handshake.
REQ-040 In W_RESP the block SHALL drive bvalid=1, bid=latched awid, and bresp=SLVERR if any beat errored, else OKAY. These SHALL hold until bready, then the FSM SHALL return to W_IDLE.
REQ-041 The read and write channels SHALL operate concurrently. A read and write to the same word in the same cycle SHALL return the pre-write data.
Reset
REQ-042 While reset is asserted: both FSMs idle; arready, awready, rvalid, wready, bvalid and rlast are 0; rid, bid, rresp, bresp and rdata are 0. arready and awready SHALL rise the first cycle after deassertion. Reset mid-burst SHALL drop the transaction with no response. Memory contents SHALL NOT be reset.
Structure
REQ-043 A shared package axi_pkg SHALL hold AXI_DATA_WIDTH=128, ID width 4, the burst encodings (FIXED/INCR/WRAP), the resp encodings (OKAY/SLVERR) and the FSM state enums. One sub-module, axi_sram_mem, SHALL implement 128-bit byte-enabled storage with one synchronous read port and one write port.
Verification
REQ-044 Single write then read: awaddr=BASE, awlen=0, wstrb=16'hFFFF, wdata=X; then read of the same address -> bresp=0 and bid echoed; rdata=X, rlast=1 on beat 0, rresp=0.
REQ-045 INCR write with awlen=3 and wstrb=16'h000F, then INCR read with arlen=3 and rready toggled every cycle -> only the low 4 bytes change; 4 beats returned; data held stable during stalls; rlast on beat 3 only.
REQ-046 Read with araddr=BASE+16*MEM_WORDS-16, arlen=1 -> beat 0 OKAY; beat 1 SLVERR with rdata 0. WRAP burst -> all beats SLVERR.
REQ-047 Write with awlen=2 and wlast on beat 1 -> bresp=2'b10. Write with awlen=255 -> 256 beats accepted, then bresp=0.
REQ-048 Assert reset mid-read-burst -> rvalid=0 immediately; arready=1 the cycle after deassertion; a subsequent read returns data written before the reset.
